// File: rtl/alu_reg_pkg.sv
// Shared definitions for the ALU register-file sequencer: ALU_OP encodings
// and the issue/writeback FSM state type.
package alu_reg_pkg;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_reg_file.sv
// Register storage for the sequencer: REG_COUNT x WORD_SIZE words, async
// clear, three combinational read ports and one write port. Register 0 is
// hard-wired to zero: writes to it are dropped and every read port returns 0.
module alu_reg_file #(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [ADDR_W-1:0]    ra1,
  input  logic [ADDR_W-1:0]    ra2,
  input  logic [ADDR_W-1:0]    ra_dbg,
  output logic [WORD_SIZE-1:0] rd1,
  output logic [WORD_SIZE-1:0] rd2,
  output logic [WORD_SIZE-1:0] rd_dbg
);

  logic [WORD_SIZE-1:0] mem [REG_COUNT];

  // Storage update: async clear, single write port, r0 writes discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational reads with r0 forced to zero.
  always_comb begin
    rd1    = (ra1    == '0) ? '0 : mem[ra1];
    rd2    = (ra2    == '0) ? '0 : mem[ra2];
    rd_dbg = (ra_dbg == '0) ? '0 : mem[ra_dbg];
  end

endmodule

// File: rtl/alu_reg_seq.sv
// Issue/writeback sequencer around an external 8-function ALU mux.
// Accepts one instruction per handshake, presents its operands to the ALU,
// captures the result and writes it back to the register file. An external
// load port presets registers while the sequencer is idle.
// Optional feature macro: ALU_REG_FWD_EN (accept in WB plus operand forwarding
// from the write-back stage).
//
//   state | meaning
//   IDLE  | waiting for an instruction; load port usable when no instruction
//   EXEC  | alu_op/alu_a/alu_b driven from registers, result captured at end
//   WB    | wb_valid pulse, result written to reg[wb_rd] at end of cycle
module alu_reg_seq
  import alu_reg_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [2:0]           instr_op,
  input  logic [ADDR_W-1:0]    instr_rd,
  input  logic [ADDR_W-1:0]    instr_rs1,
  input  logic [ADDR_W-1:0]    instr_rs2,
  input  logic                 ld_en,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  output logic                 ld_ack,
  output logic [2:0]           alu_op,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  input  logic [WORD_SIZE-1:0] alu_r,
  output logic                 wb_valid,
  output logic [ADDR_W-1:0]    wb_rd,
  output logic [WORD_SIZE-1:0] wb_data,
  input  logic [ADDR_W-1:0]    dbg_addr,
  output logic [WORD_SIZE-1:0] dbg_data
);

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic                 ld_do;
  logic [ADDR_W-1:0]    rd_q;
  logic [WORD_SIZE-1:0] rf_rs1;
  logic [WORD_SIZE-1:0] rf_rs2;
  logic [WORD_SIZE-1:0] opnd_a;
  logic [WORD_SIZE-1:0] opnd_b;
  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_waddr;
  logic [WORD_SIZE-1:0] rf_wdata;

`ifdef ALU_REG_FWD_EN
  assign instr_ready = (state == IDLE) || (state == WB);
  // During WB the register file has not been written yet, so a dependent
  // operand takes the pending write-back value instead.
  assign opnd_a = ((state == WB) && (instr_rs1 == wb_rd) && (instr_rs1 != '0)) ? wb_data : rf_rs1;
  assign opnd_b = ((state == WB) && (instr_rs2 == wb_rd) && (instr_rs2 != '0)) ? wb_data : rf_rs2;
`else
  assign instr_ready = (state == IDLE);
  assign opnd_a      = rf_rs1;
  assign opnd_b      = rf_rs2;
`endif

  assign accept   = instr_valid && instr_ready;
  // The instruction wins over a simultaneous load; rst_n gating keeps the
  // ack low while reset is held.
  assign ld_do    = rst_n && ld_en && (state == IDLE) && !instr_valid;
  assign ld_ack   = ld_do;
  assign wb_valid = (state == WB);

  // Write port mux: load and write-back never coincide because load needs IDLE.
  assign rf_we    = wb_valid || ld_do;
  assign rf_waddr = wb_valid ? wb_rd   : ld_addr;
  assign rf_wdata = wb_valid ? wb_data : ld_data;

  alu_reg_file #(
    .WORD_SIZE (WORD_SIZE),
    .REG_COUNT (REG_COUNT),
    .ADDR_W    (ADDR_W)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .ra1    (instr_rs1),
    .ra2    (instr_rs2),
    .ra_dbg (dbg_addr),
    .rd1    (rf_rs1),
    .rd2    (rf_rs2),
    .rd_dbg (dbg_data)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; WB only returns to EXEC when it may accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction capture at accept and result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op  <= OP_MOV;
      alu_a   <= '0;
      alu_b   <= '0;
      rd_q    <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      if (accept) begin
        alu_op <= instr_op;
        alu_a  <= opnd_a;
        alu_b  <= opnd_b;
        rd_q   <= instr_rd;
      end
      if (state == EXEC) begin
        wb_data <= alu_r;
        wb_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_reg_seq.sv
// Self-checking bench for alu_reg_seq with a behavioural ALU mux closing the
// alu_* -> alu_r loop. Expected write-backs are queued at accept and checked
// by a monitor when wb_valid appears.
module tb_alu_reg_seq;
  import alu_reg_pkg::*;

  localparam int W  = 32;
  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic          ld_ack;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_a, alu_b, alu_r;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [W-1:0]  wb_data;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_MOV:  return a;
      OP_NOT:  return ~a;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  assign alu_r = alu_fn(alu_op, alu_a, alu_b);

  alu_reg_seq #(.WORD_SIZE(W), .REG_COUNT(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
    int            acc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model [N];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wb_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every write-back pulse must match the oldest queued
  // expectation and arrive two cycles after its accept.
  always @(negedge clk) begin : wb_mon
    exp_t e;
    if (rst_n && wb_valid) begin
      wb_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=%h, required no write-back", wb_rd, wb_data);
      end else begin
        e = sb.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data) begin
          errors++;
          $display("FAIL wb_result: got rd=%0d data=%h, required rd=%0d data=%h", wb_rd, wb_data, e.rd, e.data);
        end
        checks++;
        if (cyc != e.acc + 2) begin
          errors++;
          $display("FAIL wb_latency: got cycle %0d, required %0d", cyc, e.acc + 2);
        end
      end
    end
  end

  task automatic do_load(input logic [AW-1:0] addr, input logic [W-1:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    #1;
    checks++;
    if (ld_ack !== 1'b1) begin
      errors++;
      $display("FAIL load_ack: addr=%0d got ld_ack=%b, required 1", addr, ld_ack);
    end
    @(negedge clk);
    ld_en = 1'b0;
    if (addr != '0) model[addr] = data;
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, output int acc);
    exp_t e;
    int n;
    n = 0;
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    #1;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!instr_ready) begin
      errors++;
      $display("FAIL accept_timeout: instr_ready=%b after %0d cycles, required 1", instr_ready, n);
      instr_valid = 1'b0;
      acc = -1;
    end else begin
      e.rd = rd;
      e.data = alu_fn(op, model[rs1], model[rs2]);
      e.acc = cyc;
      sb.push_back(e);
      if (rd != '0) model[rd] = e.data;
      acc = cyc;
      @(negedge clk);
      instr_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || ld_ack !== 1'b0 || alu_op !== 3'd0 || alu_a !== '0 || alu_b !== '0 ||
        wb_rd !== '0 || wb_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wb_valid=%b ld_ack=%b op=%0d a=%h b=%h rd=%0d data=%h, required all 0",
               wb_valid, ld_ack, alu_op, alu_a, alu_b, wb_rd, wb_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", instr_ready);
    end
  endtask

  task automatic test_reset_mid_exec();
    int acc;
    int wb_before;
    do_load(5'd1, 32'h11);
    do_load(5'd9, 32'h99);
    issue(OP_MOV, 5'd2, 5'd1, 5'd0, acc);
    wb_before = wb_count;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || alu_a !== '0) begin
      errors++;
      $display("FAIL midexec_reset_out: got wb_valid=%b alu_a=%h, required 0 and 0", wb_valid, alu_a);
    end
    repeat (2) @(negedge clk);
    sb.delete();
    for (int i = 0; i < N; i++) model[i] = '0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (wb_count != wb_before) begin
      errors++;
      $display("FAIL midexec_no_wb: got %0d pulses, required 0", wb_count - wb_before);
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL midexec_ready: got %b, required 1", instr_ready);
    end
    for (int i = 0; i < N; i++) begin
      dbg_addr = AW'(i);
      #1;
      checks++;
      if (dbg_data !== '0) begin
        errors++;
        $display("FAIL midexec_clear: r%0d got %h, required 0", i, dbg_data);
      end
    end
  endtask

  task automatic test_load_add();
    int acc;
    do_load(5'd1, 32'd5);
    do_load(5'd2, 32'd3);
    issue(OP_ADD, 5'd3, 5'd1, 5'd2, acc);
    wait_drain();
    dbg_addr = 5'd3;
    #1;
    checks++;
    if (dbg_data !== 32'd8) begin
      errors++;
      $display("FAIL add_r3: got %h, required 00000008", dbg_data);
    end
  endtask

  task automatic test_sub_slt();
    int acc;
    do_load(5'd1, 32'd2);
    do_load(5'd2, 32'd7);
    issue(OP_SUB, 5'd4, 5'd1, 5'd2, acc);
    issue(OP_SLT, 5'd5, 5'd1, 5'd2, acc);
    issue(OP_SLT, 5'd6, 5'd2, 5'd1, acc);
    wait_drain();
    dbg_addr = 5'd4;
    #1;
    checks++;
    if (dbg_data !== 32'hFFFF_FFFB) begin
      errors++;
      $display("FAIL sub_r4: got %h, required fffffffb", dbg_data);
    end
    dbg_addr = 5'd5;
    #1;
    checks++;
    if (dbg_data !== 32'd1) begin
      errors++;
      $display("FAIL slt_r5: got %h, required 00000001", dbg_data);
    end
    dbg_addr = 5'd6;
    #1;
    checks++;
    if (dbg_data !== 32'd0) begin
      errors++;
      $display("FAIL slt_r6: got %h, required 00000000", dbg_data);
    end
  endtask

  task automatic test_r0();
    int acc;
    int wb_before;
    do_load(5'd0, 32'd9);
    wb_before = wb_count;
    issue(OP_MOV, 5'd0, 5'd1, 5'd0, acc);
    wait_drain();
    checks++;
    if (wb_count != wb_before + 1) begin
      errors++;
      $display("FAIL r0_wb_pulse: got %0d pulses, required 1", wb_count - wb_before);
    end
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (dbg_data !== '0) begin
      errors++;
      $display("FAIL r0_read: got %h, required 0", dbg_data);
    end
  endtask

  task automatic test_load_blocked();
    exp_t e;
    instr_valid = 1'b1; instr_op = OP_ADD; instr_rd = 5'd7; instr_rs1 = 5'd1; instr_rs2 = 5'd2;
    ld_en = 1'b1; ld_addr = 5'd8; ld_data = 32'hAA;
    #1;
    checks++;
    if (ld_ack !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL blocked_handshake: got ld_ack=%b instr_ready=%b, required 0 and 1", ld_ack, instr_ready);
    end
    e.rd = 5'd7;
    e.data = 32'd9;
    e.acc = cyc;
    sb.push_back(e);
    model[7] = 32'd9;
    @(negedge clk);
    instr_valid = 1'b0;
    ld_en = 1'b0;
    wait_drain();
    dbg_addr = 5'd8;
    #1;
    checks++;
    if (dbg_data !== '0) begin
      errors++;
      $display("FAIL blocked_target: r8 got %h, required 0", dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, gap;
    do_load(5'd1, 32'd5);
    do_load(5'd2, 32'd3);
    issue(OP_ADD, 5'd3, 5'd1, 5'd2, acc1);
    issue(OP_ADD, 5'd4, 5'd3, 5'd3, acc2);
    wait_drain();
`ifdef ALU_REG_FWD_EN
    gap = 2;
`else
    gap = 3;
`endif
    checks++;
    if (acc2 - acc1 != gap) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles, required %0d", acc2 - acc1, gap);
    end
    dbg_addr = 5'd4;
    #1;
    checks++;
    if (dbg_data !== 32'd16) begin
      errors++;
      $display("FAIL b2b_r4: got %h, required 00000010", dbg_data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    for (int i = 0; i < N; i++) model[i] = '0;
    @(negedge clk);
    test_reset();
    test_reset_mid_exec();
    test_load_add();
    test_sub_slt();
    test_r0();
    test_load_blocked();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
